// File: rtl/cf_spi_target_pkg.sv
// Shared register map, status/mask bit positions and SPI mode for the SPI target.
package cf_spi_target_pkg;

    localparam logic [1:0] RXDATA = 2'd0;
    localparam logic [1:0] TXDATA = 2'd1;
    localparam logic [1:0] STATUS = 2'd2;
    localparam logic [1:0] IM     = 2'd3;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_OVF   = 2;
    localparam int ST_TX_UDF   = 3;
    localparam int ST_BUSY     = 4;

    localparam int IM_RX_VALID = 0;
    localparam int IM_TX_EMPTY = 1;
    localparam int IM_RX_OVF   = 2;
    localparam int IM_TX_UDF   = 3;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE = 2'b00;

    function automatic logic [3:0] irq_src(input logic rx_valid, input logic tx_full,
                                           input logic rx_ovf, input logic tx_udf);
        logic [3:0] s;
        s              = '0;
        s[IM_RX_VALID] = rx_valid;
        s[IM_TX_EMPTY] = ~tx_full;
        s[IM_RX_OVF]   = rx_ovf;
        s[IM_TX_UDF]   = tx_udf;
        return s;
    endfunction

endpackage

// File: rtl/cf_spi_target_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with selectable reset level.
module cf_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= {STAGES{RST_VAL}};
        else         sync_q <= sync_d;
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cf_spi_target.sv
// SPI mode-0 target with byte-wide RX/TX holding registers behind a Wishbone classic slave.
module cf_spi_target
    import cf_spi_target_pkg::*;
#(
    parameter logic [7:0] FILL        = 8'hFF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    output logic        ack_o,
    output logic        IRQ,
    input  logic        sclk,
    input  logic        csb,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
);

    logic sclk_s, csb_s, mosi_s;

    // csb idles high so the chain resets high; no spurious fall after reset.
    cf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(sclk), .q_o(sclk_s));
    cf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(csb), .q_o(csb_s));
    cf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(mosi), .q_o(mosi_s));

    logic        sclk_prev_q, sclk_prev_d;
    logic        csb_prev_q, csb_prev_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        reload_q, reload_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  tx_buf_q, tx_buf_d;
    logic        tx_full_q, tx_full_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_ovf_q, rx_ovf_d;
    logic        tx_udf_q, tx_udf_d;
    logic [3:0]  im_q, im_d;
    logic        oe_q, oe_d;

    logic       req, wr, rd, rd_rx;
    logic [1:0] addr;
    logic       sclk_lvl, sclk_rise, sclk_fall, csb_fall, csb_rise;
    logic       spi_rise, spi_fall, load;
    logic       unused_bus;

    assign unused_bus = ^{sel_i, adr_i[31:4], adr_i[1:0], dat_i[31:8]};

    assign req   = cyc_i & stb_i & ~ack_q;
    assign wr    = req & we_i;
    assign rd    = req & ~we_i;
    assign addr  = adr_i[3:2];
    assign rd_rx = rd && (addr == RXDATA);

    assign sclk_lvl  = sclk_s ^ SPI_MODE[1];
    assign sclk_rise = sclk_lvl & ~sclk_prev_q;
    assign sclk_fall = ~sclk_lvl & sclk_prev_q;
    assign csb_fall  = ~csb_s & csb_prev_q;
    assign csb_rise  = csb_s & ~csb_prev_q;
    assign spi_rise  = sclk_rise & ~csb_s & ~csb_fall;
    assign spi_fall  = sclk_fall & ~csb_s & ~csb_fall;
    // A new TX byte is fetched at frame start and on the first fall after each full byte.
    assign load      = csb_fall | (spi_fall & reload_q);

    always_comb begin
        sclk_prev_d = sclk_lvl;
        csb_prev_d  = csb_s;
        ack_d       = req;
        dat_d       = '0;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        reload_d    = reload_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_ovf_d    = rx_ovf_q;
        tx_udf_d    = tx_udf_q;
        im_d        = im_q;
        oe_d        = oe_q;
        irq_d       = |(im_q & irq_src(rx_valid_q, tx_full_q, rx_ovf_q, tx_udf_q));

        if (rd) begin
            case (addr)
                RXDATA: dat_d[7:0] = rx_data_q;
                STATUS: begin
                    dat_d[ST_RX_VALID] = rx_valid_q;
                    dat_d[ST_TX_FULL]  = tx_full_q;
                    dat_d[ST_RX_OVF]   = rx_ovf_q;
                    dat_d[ST_TX_UDF]   = tx_udf_q;
                    dat_d[ST_BUSY]     = ~csb_s;
                end
                IM:      dat_d[3:0] = im_q;
                default: dat_d = '0;
            endcase
        end
        if (rd_rx) rx_valid_d = 1'b0;
        // Bus clears are applied before engine sets so a simultaneous set wins.
        if (wr && addr == STATUS) begin
            if (dat_i[ST_RX_OVF]) rx_ovf_d = 1'b0;
            if (dat_i[ST_TX_UDF]) tx_udf_d = 1'b0;
        end
        if (wr && addr == IM) im_d = dat_i[3:0];

        if (csb_rise) begin
            bit_cnt_d = '0;
            reload_d  = 1'b0;
            oe_d      = 1'b0;
        end
        if (csb_fall) begin
            bit_cnt_d = '0;
            reload_d  = 1'b0;
            oe_d      = 1'b1;
        end

        if (load) begin
            if (tx_full_q) begin
                tx_shift_d = tx_buf_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d = FILL;
                tx_udf_d   = 1'b1;
            end
            reload_d = 1'b0;
        end else if (spi_fall) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end

        if (spi_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            if (bit_cnt_q == 3'd7) begin
                bit_cnt_d = '0;
                reload_d  = 1'b1;
                // A same-cycle RXDATA read has already taken the old byte.
                if (!rx_valid_q || rd_rx) begin
                    rx_data_d  = rx_shift_d;
                    rx_valid_d = 1'b1;
                end else begin
                    rx_ovf_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end

        if (wr && addr == TXDATA) begin
            tx_buf_d  = dat_i[7:0];
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_prev_q <= 1'b0;
            csb_prev_q  <= 1'b1;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_q       <= 1'b0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            reload_q    <= 1'b0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_udf_q    <= 1'b0;
            im_q        <= '0;
            oe_q        <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_prev_d;
            csb_prev_q  <= csb_prev_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            irq_q       <= irq_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            reload_q    <= reload_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_udf_q    <= tx_udf_d;
            im_q        <= im_d;
            oe_q        <= oe_d;
        end
    end

    assign ack_o   = ack_q;
    assign dat_o   = dat_q;
    assign IRQ     = irq_q;
    assign miso_oe = oe_q;
    assign miso    = oe_q & tx_shift_q[7];

endmodule

// File: tb/tb_cf_spi_target.sv
// Directed bench for cf_spi_target: a transaction-level model of the register file and SPI byte flow.
module tb_cf_spi_target;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel_i = 4'hF;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic        ack_o;
    logic        IRQ;
    logic        sclk = 1'b0;
    logic        csb = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;

    cf_spi_target dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o),
        .IRQ(IRQ), .sclk(sclk), .csb(csb), .mosi(mosi), .miso(miso), .miso_oe(miso_oe));

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Model state: what software would believe about the target.
    logic [7:0] m_tx_buf = '0;
    logic       m_tx_full = 1'b0;
    logic [7:0] m_rx_data = '0;
    logic       m_rx_valid = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [3:0] m_im = '0;
    logic       tb_busy = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_irq();
        logic [3:0] src;
        src = {m_udf, m_ovf, ~m_tx_full, m_rx_valid};
        return |(m_im & src);
    endfunction

    function automatic logic [31:0] m_status();
        return {27'b0, 1'b0, m_udf, m_ovf, m_tx_full, m_rx_valid};
    endfunction

    // Quiet-bus checker: once nothing has happened for a few cycles, outputs must be at rest.
    int idle_cnt = 0;
    always @(negedge clk_i) begin
        if (!rst_ni || tb_busy) begin
            idle_cnt = 0;
        end else begin
            idle_cnt++;
            if (idle_cnt >= 4) begin
                chk("idle_irq", {31'b0, IRQ}, {31'b0, m_irq()});
                chk("idle_oe", {31'b0, miso_oe}, 32'd0);
                chk("idle_miso", {31'b0, miso}, 32'd0);
                chk("idle_ack", {31'b0, ack_o}, 32'd0);
            end
        end
    end

    task automatic wb(input logic w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] r);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = {28'b0, a, 2'b00}; dat_i = d;
        @(negedge clk_i);
        chk("ack", {31'b0, ack_o}, 32'd1);
        r = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        tb_busy = 1'b1;
        wb(1'b1, a, d, r);
        case (a)
            2'd1: begin m_tx_buf = d[7:0]; m_tx_full = 1'b1; end
            2'd2: begin if (d[2]) m_ovf = 1'b0; if (d[3]) m_udf = 1'b0; end
            2'd3: m_im = d[3:0];
            default: ;
        endcase
        tb_busy = 1'b0;
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] r);
        logic [31:0] exp;
        tb_busy = 1'b1;
        case (a)
            2'd0: exp = {24'b0, m_rx_data};
            2'd2: exp = m_status();
            2'd3: exp = {28'b0, m_im};
            default: exp = '0;
        endcase
        wb(1'b0, a, 32'd0, r);
        chk("rd_model", r, exp);
        if (a == 2'd0) m_rx_valid = 1'b0;
        tb_busy = 1'b0;
    endtask

    function automatic void m_rx_done(input logic [7:0] b);
        if (!m_rx_valid) begin m_rx_data = b; m_rx_valid = 1'b1; end
        else m_ovf = 1'b1;
    endfunction

    // One csb-low frame of nbits, 4 clk per sclk phase; sclk falls together with csb rise.
    // rd_mid issues an RXDATA read that lands on the byte-complete cycle.
    task automatic spi_frame(input logic [7:0] mo, input int nbits, input logic rd_mid,
                             output logic [7:0] got, output logic [31:0] rd_val);
        logic [7:0] exp_tx;
        tb_busy = 1'b1;
        got = '0; rd_val = '0;
        if (m_tx_full) begin exp_tx = m_tx_buf; m_tx_full = 1'b0; end
        else begin exp_tx = 8'hFF; m_udf = 1'b1; end
        @(negedge clk_i);
        csb = 1'b0; mosi = mo[7];
        repeat (4) @(negedge clk_i);
        chk("oe_frame", {31'b0, miso_oe}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            got[7-i] = miso;
            chk("miso_bit", {31'b0, miso}, {31'b0, exp_tx[7-i]});
            sclk = 1'b1;
            if (rd_mid && i == 7) begin
                repeat (2) @(negedge clk_i);
                cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h0;
                @(negedge clk_i);
                chk("ack_mid", {31'b0, ack_o}, 32'd1);
                rd_val = dat_o;
                chk("rd_mid_model", rd_val, {24'b0, m_rx_data});
                m_rx_valid = 1'b0;
                cyc_i = 1'b0; stb_i = 1'b0;
                @(negedge clk_i);
            end else begin
                repeat (4) @(negedge clk_i);
            end
            sclk = 1'b0;
            if (i == nbits - 1) csb = 1'b1;
            else mosi = mo[6-i];
            repeat (4) @(negedge clk_i);
        end
        csb = 1'b1; mosi = 1'b0;
        repeat (4) @(negedge clk_i);
        if (nbits == 8) m_rx_done(mo);
        tb_busy = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, rv;
        logic [7:0]  g;

        repeat (3) @(negedge clk_i);
        chk("rst_ack", {31'b0, ack_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", {31'b0, IRQ}, 32'd0);
        chk("rst_miso", {31'b0, miso}, 32'd0);
        chk("rst_oe", {31'b0, miso_oe}, 32'd0);
        rst_ni = 1'b1;
        tb_busy = 1'b0;
        repeat (6) @(negedge clk_i);

        // 1: reset status and tx-empty interrupt
        wb_rd(2'd2, r);  chk("t1_status", r, 32'h0);
        wb_wr(2'd3, 32'h2);
        repeat (3) @(negedge clk_i);
        chk("t1_irq", {31'b0, IRQ}, 32'd1);
        wb_rd(2'd3, r);  chk("t1_im", r, 32'h2);
        wb_wr(2'd3, 32'h0);
        repeat (6) @(negedge clk_i);

        // 2: normal exchange
        wb_wr(2'd1, 32'hA5);
        spi_frame(8'h3C, 8, 1'b0, g, rv);
        chk("t2_miso", {24'b0, g}, 32'hA5);
        wb_rd(2'd2, r);  chk("t2_status", r, 32'h01);
        wb_rd(2'd0, r);  chk("t2_rx", r, 32'h3C);
        wb_rd(2'd2, r);  chk("t2_status2", r, 32'h00);

        // 3: underrun
        spi_frame(8'h96, 8, 1'b0, g, rv);
        chk("t3_miso", {24'b0, g}, 32'hFF);
        wb_rd(2'd2, r);  chk("t3_status", r, 32'h09);
        wb_wr(2'd2, 32'h8);
        wb_rd(2'd2, r);  chk("t3_w1c", r, 32'h01);
        wb_rd(2'd0, r);  chk("t3_rx", r, 32'h96);

        // 4: overflow keeps the first byte
        spi_frame(8'h11, 8, 1'b0, g, rv);
        spi_frame(8'h22, 8, 1'b0, g, rv);
        wb_rd(2'd0, r);  chk("t4_rx", r, 32'h11);
        wb_rd(2'd2, r);  chk("t4_status", r, 32'h0C);
        wb_wr(2'd3, 32'h4);
        repeat (3) @(negedge clk_i);
        chk("t4_irq", {31'b0, IRQ}, 32'd1);
        wb_wr(2'd2, 32'hC);
        wb_wr(2'd3, 32'h0);
        wb_rd(2'd2, r);  chk("t4_clr", r, 32'h00);

        // 5: aborted partial byte
        spi_frame(8'hFF, 5, 1'b0, g, rv);
        wb_rd(2'd2, r);  chk("t5_status", r, 32'h08);
        wb_wr(2'd2, 32'h8);
        spi_frame(8'h5A, 8, 1'b0, g, rv);
        wb_rd(2'd0, r);  chk("t5_rx", r, 32'h5A);

        // 6: read collides with byte completion
        wb_wr(2'd2, 32'h8);
        wb_wr(2'd1, 32'h81);
        spi_frame(8'h12, 8, 1'b0, g, rv);
        chk("t6_miso", {24'b0, g}, 32'h81);
        spi_frame(8'h34, 8, 1'b1, g, rv);
        chk("t6_rd_old", rv, 32'h12);
        wb_rd(2'd2, r);  chk("t6_status", r, 32'h09);
        wb_rd(2'd0, r);  chk("t6_rx", r, 32'h34);
        wb_rd(2'd2, r);  chk("t6_status2", r, 32'h08);

        repeat (8) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
